// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the floating-point unit arbiter.
// The FP_* encodings are common IEEE-754 single operands used by benches.
package fp_arb_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_HALF = 32'h3F00_0000;
    localparam logic [FP_W-1:0] FP_128  = 32'h4300_0000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    // Rotation step used for the round-robin pointer.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr wins,
// wrapping around via a doubled request vector.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    logic [2*N_REQ-1:0] doubled;
    logic [2*N_REQ-1:0] masked;

    // The upper copy is never masked, so any request is found after wrap-around.
    always_comb begin
        doubled = {req, req};
        masked  = doubled & ({(2*N_REQ){1'b1}} << ptr);
        win_idx = '0;
        win     = '0;
        for (int j = 2*N_REQ-1; j >= 0; j--) begin
            if (masked[j]) begin
                win_idx = IDX_W'(j % N_REQ);
            end
        end
        if (|req) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one enable/done floating-point unit among N_REQ
// requesters, with operand latching at grant and a BUSY watchdog.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = FP_W,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_dataa,
    input  logic [N_REQ*DATA_W-1:0] req_datab,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    err,
    output logic [DATA_W-1:0]       result,
    output logic                    unit_enable,
    output logic [DATA_W-1:0]       unit_dataa,
    output logic [DATA_W-1:0]       unit_datab,
    input  logic [DATA_W-1:0]       unit_result,
    input  logic                    unit_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [WD_W-1:0]    wdog;
    logic [N_REQ-1:0]   win;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_a = req_dataa[i*DATA_W +: DATA_W];
                sel_b = req_datab[i*DATA_W +: DATA_W];
            end
        end
    end

    // RELEASE waits out a lingering done so it cannot complete the next owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= '0;
            ack         <= '0;
            err         <= 1'b0;
            result      <= '0;
            unit_enable <= 1'b0;
            unit_dataa  <= '0;
            unit_datab  <= '0;
            ptr         <= '0;
            owner       <= '0;
            wdog        <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        unit_dataa  <= sel_a;
                        unit_datab  <= sel_b;
                        gnt         <= win;
                        owner       <= win_idx;
                        unit_enable <= 1'b1;
                        wdog        <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (unit_done || wdog == WD_LAST) begin
                        if (unit_done) begin
                            result <= unit_result;
                        end else begin
                            err <= 1'b1;
                        end
                        ack         <= gnt;
                        gnt         <= '0;
                        unit_enable <= 1'b0;
                        ptr         <= IDX_W'(rr_next(int'(owner), N_REQ));
                        state       <= RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!unit_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Randomized and directed bench for fp_unit_arbiter against a transaction-level
// reference model and a behavioural multiplier unit.
module tb_fp_unit_arbiter;
    import fp_arb_pkg::*;

    localparam int N = 4;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req;
    logic [N*32-1:0] req_dataa, req_datab;
    logic [N-1:0] gnt, ack;
    logic err, unit_enable, unit_done;
    logic [31:0] result, unit_dataa, unit_datab, unit_result;

    logic [31:0] opa [N];
    logic [31:0] opb [N];
    int unit_mode = 0;   // 0: normal, 1: done lingers one cycle, 2: never done
    int unit_lat = 5;
    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;
    bit mon_on = 1'b0;

    logic [31:0] fp_table [8] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h40400000,
                                  32'h43000000, 32'h3FC00000, 32'hC0000000, 32'h40A00000};

    fp_unit_arbiter #(.N_REQ(N), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
        .gnt(gnt), .ack(ack), .err(err), .result(result), .unit_enable(unit_enable),
        .unit_dataa(unit_dataa), .unit_datab(unit_datab), .unit_result(unit_result),
        .unit_done(unit_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_dataa = '0;
        req_datab = '0;
        for (int i = 0; i < N; i++) begin
            req_dataa[i*32 +: 32] = opa[i];
            req_datab[i*32 +: 32] = opb[i];
        end
    end

    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:0] == '0) return {s[31], 63'b0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == '0) return {d[63], 31'b0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        return d2s($realtobits(ra * rb));
    endfunction

    // Behavioural shared unit: done rises unit_lat cycles after enable.
    int ucnt;
    logic done_r;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ucnt <= 0;
            done_r <= 1'b0;
        end else if (!unit_enable) begin
            ucnt <= 0;
            done_r <= 1'b0;
        end else begin
            ucnt <= ucnt + 1;
            if (unit_mode != 2 && ucnt + 1 == unit_lat) done_r <= 1'b1;
        end
    end
    assign unit_done   = (unit_mode == 1) ? done_r : (done_r & unit_enable);
    assign unit_result = fmul(unit_dataa, unit_datab);

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h required %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic int rr_choice(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Reference model: one transaction at a time, fixed latency per unit mode.
    bit m_busy = 1'b0;
    int m_owner, m_ptr = 0, m_due, m_free_at = 0;
    logic [31:0] m_opa, m_opb, m_res, m_last_res = '0;
    logic [N-1:0] req_prev = '0, gnt_prev = '0;
    logic [31:0] a_prev [N];
    logic [31:0] b_prev [N];
    int grant_idx_q[$], grant_cyc_q[$], ack_cyc_q[$];

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr = 0;
        m_last_res = '0;
        m_free_at = cyc + 1;
    endtask

    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_gnt, exp_ack;
        logic exp_err;
        if (mon_on && !reset) begin
            exp_ack = '0;
            exp_err = 1'b0;
            if (!m_busy && cyc >= m_free_at && req_prev != '0) begin
                m_owner = rr_choice(req_prev, m_ptr);
                m_busy = 1'b1;
                m_opa = a_prev[m_owner];
                m_opb = b_prev[m_owner];
                m_res = fmul(m_opa, m_opb);
                m_due = cyc + ((unit_mode == 2) ? TMO : unit_lat + 1);
            end
            exp_gnt = m_busy ? N'(1 << m_owner) : '0;
            if (m_busy && cyc == m_due) begin
                exp_ack = exp_gnt;
                exp_gnt = '0;
                exp_err = (unit_mode == 2);
                if (!exp_err) m_last_res = m_res;
                m_busy = 1'b0;
                m_ptr = (m_owner + 1) % N;
                m_free_at = cyc + ((unit_mode == 1) ? 3 : 2);
            end
            check_output("ctl", {gnt, ack, err, unit_enable}, {exp_gnt, exp_ack, exp_err, m_busy});
            check_output("result", result, m_last_res);
            if (m_busy) begin
                check_output("unit_dataa", unit_dataa, m_opa);
                check_output("unit_datab", unit_datab, m_opb);
            end
            if (gnt != '0 && gnt_prev == '0) begin
                grant_idx_q.push_back($clog2(gnt));
                grant_cyc_q.push_back(cyc);
            end
            if (ack != '0) ack_cyc_q.push_back(cyc);
        end
        req_prev = req;
        gnt_prev = gnt;
        for (int i = 0; i < N; i++) begin
            a_prev[i] = opa[i];
            b_prev[i] = opb[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_idx_q.delete();
        grant_cyc_q.delete();
        ack_cyc_q.delete();
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_gnt(input int idx, input int limit);
        bit seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (gnt[idx]) seen = 1'b1;
        end
        #1;
        check_output($sformatf("gnt%0d_wait", idx), seen, 1);
    endtask

    task automatic wait_ack(input int idx, input int limit);
        bit seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (ack[idx]) seen = 1'b1;
        end
        #1;
        check_output($sformatf("ack%0d_wait", idx), seen, 1);
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        opa[i] = fp_table[$urandom_range(0, 7)];
                        opb[i] = fp_table[$urandom_range(0, 7)];
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (gnt[i] && $urandom_range(0, 3) == 0) begin
                    opa[i] = fp_table[$urandom_range(0, 7)];
                    opb[i] = fp_table[$urandom_range(0, 7)];
                end else if (gnt[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                opa[i] = fp_table[$urandom_range(0, 7)];
                opb[i] = fp_table[$urandom_range(0, 7)];
            end
        end
    endtask

    initial begin
        int drive_cyc;
        bit got5;
        reset = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        repeat (3) tick();
        check_output("reset_ctl", {gnt, ack, err, unit_enable}, 0);
        check_output("reset_result", result, 0);
        check_output("reset_ops", {unit_dataa, unit_datab}, 0);
        reset = 1'b0;
        model_reset();
        mon_on = 1'b1;

        // Single requester, 2.0 x 3.0
        tick();
        clear_logs();
        opa[0] = 32'h40000000;
        opb[0] = 32'h40400000;
        req[0] = 1'b1;
        drive_cyc = cyc;
        wait_ack(0, 20);
        check_output("single_result", result, 32'h40C00000);
        check_output("single_gnt_lat", grant_cyc_q[0] - drive_cyc, 1);
        check_output("single_ack_lat", ack_cyc_q[0] - grant_cyc_q[0], 6);
        tick();
        req[0] = 1'b0;
        repeat (4) tick();

        // All four requesting continuously from ptr=0
        pulse_reset();
        clear_logs();
        for (int i = 0; i < N; i++) begin
            opa[i] = fp_table[i];
            opb[i] = fp_table[i + 4];
        end
        req = '1;
        got5 = 1'b0;
        for (int k = 0; k < 200 && !got5; k++) begin
            @(negedge clk);
            #1;
            if (grant_idx_q.size() >= 5) got5 = 1'b1;
        end
        check_output("rr_five_grants", got5, 1);
        for (int k = 0; k < 5; k++) check_output($sformatf("rr_order%0d", k), grant_idx_q[k], k % N);
        for (int k = 0; k < 4; k++)
            check_output($sformatf("rr_gap%0d", k), grant_cyc_q[k+1] - grant_cyc_q[k], unit_lat + 3);
        check_output("rr_acks", ack_cyc_q.size(), 4);
        tick();
        req = '0;
        repeat (12) tick();

        // Operands changed right after grant must not reach the unit
        opa[2] = FP_HALF;
        opb[2] = FP_128;
        req[2] = 1'b1;
        wait_gnt(2, 10);
        tick();
        opa[2] = FP_ONE;
        opb[2] = FP_ONE;
        @(negedge clk);
        check_output("latched_a", unit_dataa, FP_HALF);
        check_output("latched_b", unit_datab, FP_128);
        wait_ack(2, 20);
        check_output("latched_result", result, 32'h42800000);
        tick();
        req[2] = 1'b0;
        repeat (4) tick();

        // Unit never completes: watchdog abort, then next requester
        clear_logs();
        unit_mode = 2;
        opa[1] = FP_ONE;
        opb[1] = FP_128;
        req[1] = 1'b1;
        wait_gnt(1, 10);
        tick();
        opa[3] = 32'h40A00000;
        opb[3] = 32'h40000000;
        req[3] = 1'b1;
        wait_ack(1, 80);
        check_output("timeout_err", err, 1);
        check_output("timeout_result_held", result, 32'h42800000);
        check_output("timeout_lat", ack_cyc_q[0] - grant_cyc_q[0], TMO);
        tick();
        req[1] = 1'b0;
        unit_mode = 0;
        wait_gnt(3, 10);
        check_output("after_timeout_owner", grant_idx_q[1], 3);
        wait_ack(3, 20);
        check_output("after_timeout_result", result, 32'h41200000);
        tick();
        req[3] = 1'b0;
        repeat (4) tick();

        // Done lingers a cycle after enable falls
        clear_logs();
        unit_mode = 1;
        opa[0] = 32'h3FC00000;
        opb[0] = 32'h40000000;
        opa[1] = 32'h40A00000;
        opb[1] = 32'hC0000000;
        req[0] = 1'b1;
        req[1] = 1'b1;
        wait_ack(0, 20);
        check_output("sticky_result0", result, 32'h40400000);
        tick();
        req[0] = 1'b0;
        wait_ack(1, 20);
        check_output("sticky_result1", result, 32'hC1200000);
        check_output("sticky_gap", grant_cyc_q[1] - ack_cyc_q[0], 3);
        tick();
        req[1] = 1'b0;
        repeat (5) tick();
        unit_mode = 0;

        // Reset in the middle of a transaction
        req[3] = 1'b1;
        wait_gnt(3, 10);
        tick();
        #1;
        reset = 1'b1;
        #1;
        check_output("midreset_ctl", {gnt, ack, err, unit_enable}, 0);
        check_output("midreset_regs", {result, unit_dataa, unit_datab}, 0);
        req[1] = 1'b1;
        tick();
        clear_logs();
        reset = 1'b0;
        model_reset();
        wait_gnt(1, 5);
        check_output("post_reset_first", grant_idx_q[0], 1);
        wait_ack(1, 20);
        tick();
        req[1] = 1'b0;
        wait_ack(3, 20);
        tick();
        req[3] = 1'b0;
        repeat (4) tick();

        // Randomized traffic with varying unit latency
        for (int chunk = 0; chunk < 6; chunk++) begin
            unit_mode = $urandom_range(0, 1);
            unit_lat = $urandom_range(1, 8);
            for (int c = 0; c < 300; c++) begin
                tick();
                apply_stimulus();
            end
            req = '0;
            repeat (30) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
